// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:4 stream demux and its lane FIFOs.
package demux_pkg;

    localparam int NUM_LANES      = 4;
    localparam int SEL_W          = 2;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_LANE_DEPTH = 2;

    typedef logic [SEL_W-1:0] lane_idx_t;

    typedef enum logic [1:0] {
        LANE_EMPTY   = 2'd0,
        LANE_PARTIAL = 2'd1,
        LANE_FULL    = 2'd2
    } lane_state_t;

    // Round-robin successor; wraps 3 -> 0 through the 2-bit type.
    function automatic lane_idx_t next_lane(input lane_idx_t idx);
        return idx + lane_idx_t'(2'd1);
    endfunction

endpackage

// File: rtl/demux_lane_fifo.sv
// Per-lane FIFO: push/pop with occupancy counter, head word presented while non-empty.
module demux_lane_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LANE_DEPTH = DEF_LANE_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              valid,
    output logic              full
);

    localparam int PTR_W = $clog2(LANE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LANE_DEPTH);

    logic [DATA_W-1:0] mem_r [LANE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    lane_state_t       state_s;
    logic              do_push_s;
    logic              do_pop_s;

    // Lane state decode from occupancy.
    always_comb begin
        state_s = LANE_EMPTY;
        if (cnt_r == {CNT_W{1'b0}}) begin
            state_s = LANE_EMPTY;
        end else if (cnt_r == CNT_MAX) begin
            state_s = LANE_FULL;
        end else begin
            state_s = LANE_PARTIAL;
        end
    end

    assign valid     = (state_s != LANE_EMPTY);
    assign full      = (state_s == LANE_FULL);
    // A full lane never accepts, even when popping in the same cycle.
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & valid;
    assign head_data = valid ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};

    // Storage array; cleared on reset so nothing stale survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANE_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally modulo LANE_DEPTH (power of two); counter tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1'b1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/demux_1_to_4_stream.sv
// 1:4 stream demux with per-lane FIFOs. Define DEMUX_RR_SEL_EN to replace in_sel
// with an internal round-robin lane pointer.
module demux_1_to_4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LANE_DEPTH = DEF_LANE_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [SEL_W-1:0]            in_sel,
    output logic [NUM_LANES-1:0]        out_valid,
    input  logic [NUM_LANES-1:0]        out_ready,
    output logic [NUM_LANES*DATA_W-1:0] out_data,
    output logic [NUM_LANES-1:0]        lane_full
);

    lane_idx_t             sel_s;
    logic                  accept_s;
    logic [NUM_LANES-1:0]  push_s;
    logic [NUM_LANES-1:0]  full_s;

`ifdef DEMUX_RR_SEL_EN
    lane_idx_t rr_ptr_r;
    logic      unused_sel_s;

    assign unused_sel_s = ^in_sel;
    assign sel_s        = rr_ptr_r;

    // Round-robin pointer: advances only on an accepted word, so a full lane stalls rather than skips.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= lane_idx_t'(2'd0);
        end else if (accept_s) begin
            rr_ptr_r <= next_lane(rr_ptr_r);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    assign sel_s = in_sel;
`endif

    // Ready mux and one-hot push decode for the selected lane.
    always_comb begin
        in_ready = 1'b0;
        push_s   = {NUM_LANES{1'b0}};
        in_ready = ~full_s[sel_s];
        for (int i = 0; i < NUM_LANES; i++) begin
            push_s[i] = accept_s && (sel_s == lane_idx_t'(i));
        end
    end

    assign accept_s  = in_valid & in_ready;
    assign lane_full = full_s;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux_lane_fifo #(
            .DATA_W     (DATA_W),
            .LANE_DEPTH (LANE_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_s[g]),
            .push_data (in_data),
            .pop       (out_ready[g]),
            .head_data (out_data[g*DATA_W +: DATA_W]),
            .valid     (out_valid[g]),
            .full      (full_s[g])
        );
    end

endmodule

// File: tb/tb_demux_1_to_4_stream.sv
// Table-driven bench for demux_1_to_4_stream plus hand sequences for async reset and
// the DEMUX_RR_SEL_EN round-robin mode.
module tb_demux_1_to_4_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [3:0]  lane_full;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  ordy;
        logic        e_ir;
        logic [3:0]  e_ov;
        logic [3:0]  e_full;
        logic [31:0] e_od;
    } vec_t;

    vec_t vecs[$];

    demux_1_to_4_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .lane_full (lane_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [1:0] sel, input logic [7:0] data,
                                input logic [3:0] ordy, input logic e_ir, input logic [3:0] e_ov,
                                input logic [3:0] e_full, input logic [31:0] e_od);
        vec_t v;
        v.iv = iv; v.sel = sel; v.data = data; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_full = e_full; v.e_od = e_od;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'd0; out_ready = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'd0; out_ready = 4'd0;

        // 1 reset
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_lane_full", 32'(lane_full), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);

`ifndef DEMUX_RR_SEL_EN
        // 2 route (state checked before each edge)
        vecs.push_back(mk(1'b1, 2'd0, 8'hA5, 4'b1111, 1'b1, 4'b0000, 4'b0000, 32'h00000000));
        vecs.push_back(mk(1'b1, 2'd1, 8'h3C, 4'b1111, 1'b1, 4'b0001, 4'b0000, 32'h000000A5));
        vecs.push_back(mk(1'b1, 2'd2, 8'h0F, 4'b1111, 1'b1, 4'b0010, 4'b0000, 32'h00003C00));
        vecs.push_back(mk(1'b1, 2'd3, 8'hF0, 4'b1111, 1'b1, 4'b0100, 4'b0000, 32'h000F0000));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b1000, 4'b0000, 32'hF0000000));
        // 3 backpressure on lane 2, lane 0 still flows
        vecs.push_back(mk(1'b1, 2'd2, 8'h11, 4'b1011, 1'b1, 4'b0000, 4'b0000, 32'h00000000));
        vecs.push_back(mk(1'b1, 2'd2, 8'h22, 4'b1011, 1'b1, 4'b0100, 4'b0000, 32'h00110000));
        vecs.push_back(mk(1'b1, 2'd2, 8'h33, 4'b1011, 1'b0, 4'b0100, 4'b0100, 32'h00110000));
        vecs.push_back(mk(1'b1, 2'd0, 8'h44, 4'b1011, 1'b1, 4'b0100, 4'b0100, 32'h00110000));
        vecs.push_back(mk(1'b1, 2'd2, 8'h33, 4'b1011, 1'b0, 4'b0101, 4'b0100, 32'h00110044));
        vecs.push_back(mk(1'b1, 2'd2, 8'h33, 4'b1111, 1'b0, 4'b0100, 4'b0100, 32'h00110000));
        vecs.push_back(mk(1'b1, 2'd2, 8'h33, 4'b1011, 1'b1, 4'b0100, 4'b0000, 32'h00220000));
        vecs.push_back(mk(1'b0, 2'd2, 8'h00, 4'b1111, 1'b0, 4'b0100, 4'b0100, 32'h00220000));
        vecs.push_back(mk(1'b0, 2'd2, 8'h00, 4'b1111, 1'b1, 4'b0100, 4'b0000, 32'h00330000));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0000, 4'b0000, 32'h00000000));
        // 4 full lane 1: pop does not make room in the same cycle
        vecs.push_back(mk(1'b1, 2'd1, 8'h55, 4'b0000, 1'b1, 4'b0000, 4'b0000, 32'h00000000));
        vecs.push_back(mk(1'b1, 2'd1, 8'h66, 4'b0000, 1'b1, 4'b0010, 4'b0000, 32'h00005500));
        vecs.push_back(mk(1'b1, 2'd1, 8'h77, 4'b0010, 1'b0, 4'b0010, 4'b0010, 32'h00005500));
        vecs.push_back(mk(1'b1, 2'd1, 8'h77, 4'b0000, 1'b1, 4'b0010, 4'b0000, 32'h00006600));
        vecs.push_back(mk(1'b0, 2'd1, 8'h00, 4'b0010, 1'b0, 4'b0010, 4'b0010, 32'h00006600));
        vecs.push_back(mk(1'b0, 2'd1, 8'h00, 4'b0010, 1'b1, 4'b0010, 4'b0000, 32'h00007700));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0000, 4'b0000, 32'h00000000));
        // simultaneous push and pop on a non-full lane
        vecs.push_back(mk(1'b1, 2'd0, 8'h88, 4'b0000, 1'b1, 4'b0000, 4'b0000, 32'h00000000));
        vecs.push_back(mk(1'b1, 2'd0, 8'h99, 4'b0001, 1'b1, 4'b0001, 4'b0000, 32'h00000088));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, 4'b0001, 4'b0000, 32'h00000099));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0000, 4'b0000, 32'h00000000));

        foreach (vecs[k]) begin
            @(negedge clk);
            in_valid = vecs[k].iv; in_sel = vecs[k].sel;
            in_data = vecs[k].data; out_ready = vecs[k].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(vecs[k].e_ir));
            chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(vecs[k].e_ov));
            chk($sformatf("v%0d_lane_full", k), 32'(lane_full), 32'(vecs[k].e_full));
            chk($sformatf("v%0d_out_data", k), out_data, vecs[k].e_od);
        end
`endif

        // 5 two words in every lane, then async reset between edges
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_sel = 2'(k / 2); in_data = 8'(8'h10 + k); out_ready = 4'b0000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("fill_out_valid", 32'(out_valid), 32'hF);
        chk("fill_lane_full", 32'(lane_full), 32'hF);
`ifdef DEMUX_RR_SEL_EN
        chk("fill_out_data", out_data, 32'h13121110);
`else
        chk("fill_out_data", out_data, 32'h16141210);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_lane_full", 32'(lane_full), 32'h0);
        chk("arst_out_data", out_data, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_out_valid", 32'(out_valid), 32'h0);
        end
        @(negedge clk);
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
`ifdef DEMUX_RR_SEL_EN
        chk("post_rst_new_valid", 32'(out_valid), 32'h1);
        chk("post_rst_new_data", out_data, 32'h0000005A);
`else
        chk("post_rst_new_valid", 32'(out_valid), 32'h8);
        chk("post_rst_new_data", out_data, 32'h5A000000);
`endif

`ifdef DEMUX_RR_SEL_EN
        // 6 round-robin with sel held at 11
        do_reset();
        begin
            logic [3:0] exp_ov[8]   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                        4'b1111, 4'b1111, 4'b1111, 4'b1111};
            logic [3:0] exp_full[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                        4'b0001, 4'b0011, 4'b0111, 4'b1111};
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                in_valid = 1'b1; in_sel = 2'd3; in_data = 8'(8'hA0 + k); out_ready = 4'b0000;
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                chk($sformatf("rr%0d_out_valid", k), 32'(out_valid), 32'(exp_ov[k]));
                chk($sformatf("rr%0d_lane_full", k), 32'(lane_full), 32'(exp_full[k]));
            end
        end
        chk("rr_heads", out_data, 32'hA3A2A1A0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hB0; out_ready = 4'b0010;
        #1;
        chk("rr_stall_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        out_ready = 4'b0001;
        #1;
        chk("rr_no_skip_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        out_ready = 4'b0000;
        #1;
        chk("rr_room_ready", 32'(in_ready), 32'h1);
        chk("rr_lane0_head", 32'(out_data[7:0]), 32'hA4);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rr_lane0_full_again", 32'(lane_full), 32'hD);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
